simd_issue_seq: RTL and testbench

Sequencer that issues one SIMD operation into the SIMD execute stage. It accepts an operation from the main control unit and steps through a fixed sequence: S/T/D address loads over the shared `ADDRS` bus, the LO/HI result capture, the optional register-file writeback, and an optional lane-by-lane readout via `SIMD_SEL` to the scalar datapath. It sits directly upstream of the SIMD execute stage and drives every one of that stage's control inputs.

---
 rtl/simd_pkg.sv | 39 +++
 rtl/simd_lane_ctr.sv | 42 ++++
 rtl/simd_issue_seq.sv | 131 +++++++++++++
 tb/tb_simd_issue_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and sizing for the SIMD issue sequencer and its lane counter.
// No logic; no latency or backpressure of its own.
package simd_pkg;

    localparam int LANES = 8;
    localparam int FSW   = 5;
    localparam int SEL_W = $clog2(2 * LANES);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_S,
        ST_LD_T,
        ST_LD_D,
        ST_EXEC,
        ST_WB,
        ST_RD,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_LO   = 2'b01,
        RD_HI   = 2'b10,
        RD_BOTH = 2'b11
    } rd_mode_t;

    // Operation fields captured when a request is accepted.
    typedef struct packed {
        logic [FSW-1:0] op;
        logic [4:0]     s_addr;
        logic [4:0]     t_addr;
        logic [4:0]     d_addr;
        logic           wb_en;
        logic           hi_en;
        rd_mode_t       rd_mode;
    } req_t;

endpackage

// File: rtl/simd_lane_ctr.sv
// {half,idx} readout lane counter: load sets the start half, advance moves one lane.
// Updates on the clock edge after load/adv; advances only when the caller says a lane transferred.
module simd_lane_ctr
    import simd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             load_hi,
    input  logic             adv,
    input  logic             both,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    logic             half;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half <= 1'b0;
            idx  <= '0;
        end else if (load) begin
            half <= load_hi;
            idx  <= '0;
        end else if (adv) begin
            if (idx == IDX_LAST && both && !half) begin
                half <= 1'b1;
                idx  <= '0;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

    assign sel  = {half, idx};
    // A LO pass in LO-then-HI mode is never the final lane.
    assign last = (idx == IDX_LAST) && !(both && !half);

endmodule

// File: rtl/simd_issue_seq.sv
// Issues one SIMD op: S/T/D loads, LO/HI capture, optional writeback and lane readout; 5..22 cycles.
// Moore outputs from registered state; readout stalls lane-by-lane while out_rdy is low, start ignored while busy.
module simd_issue_seq
    import simd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [FSW-1:0]   op,
    input  logic [4:0]       s_addr,
    input  logic [4:0]       t_addr,
    input  logic [4:0]       d_addr,
    input  logic             wb_en,
    input  logic             hi_en,
    input  logic [1:0]       rd_mode,
    input  logic             out_rdy,
    output logic [31:0]      ADDRS,
    output logic [FSW-1:0]   FS,
    output logic             s_ld,
    output logic             t_ld,
    output logic             d_ld,
    output logic             lo_ld,
    output logic             hi_ld,
    output logic             DSIMD_EN,
    output logic [SEL_W-1:0] SIMD_SEL,
    output logic             lane_vld,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           nxt;
    req_t             req;
    logic             accept;
    logic             rd_any;
    logic [SEL_W-1:0] lane_sel;
    logic             lane_last;

    assign accept = (state == ST_IDLE) && start;
    assign rd_any = (req.rd_mode != RD_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            req   <= '0;
        end else begin
            state <= nxt;
            if (accept)
                req <= '{op: op, s_addr: s_addr, t_addr: t_addr, d_addr: d_addr,
                         wb_en: wb_en, hi_en: hi_en, rd_mode: rd_mode_t'(rd_mode)};
        end
    end

    simd_lane_ctr u_lane_ctr (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .load_hi (rd_mode_t'(rd_mode) == RD_HI),
        .adv     ((state == ST_RD) && out_rdy),
        .both    (req.rd_mode == RD_BOTH),
        .sel     (lane_sel),
        .last    (lane_last)
    );

    always_comb begin
        nxt      = state;
        ADDRS    = '0;
        FS       = '0;
        s_ld     = 1'b0;
        t_ld     = 1'b0;
        d_ld     = 1'b0;
        lo_ld    = 1'b0;
        hi_ld    = 1'b0;
        DSIMD_EN = 1'b0;
        SIMD_SEL = '0;
        lane_vld = 1'b0;
        busy     = (state != ST_IDLE);
        done     = 1'b0;

        if (state != ST_IDLE)
            FS = req.op;

        case (state)
            ST_IDLE: begin
                if (start)
                    nxt = ST_LD_S;
            end
            ST_LD_S: begin
                ADDRS = 32'(req.s_addr);
                s_ld  = 1'b1;
                nxt   = ST_LD_T;
            end
            ST_LD_T: begin
                ADDRS = 32'(req.t_addr);
                t_ld  = 1'b1;
                nxt   = ST_LD_D;
            end
            ST_LD_D: begin
                ADDRS = 32'(req.d_addr);
                d_ld  = 1'b1;
                nxt   = ST_EXEC;
            end
            ST_EXEC: begin
                lo_ld = 1'b1;
                hi_ld = req.hi_en;
                if (req.wb_en)
                    nxt = ST_WB;
                else if (rd_any)
                    nxt = ST_RD;
                else
                    nxt = ST_DONE;
            end
            ST_WB: begin
                DSIMD_EN = 1'b1;
                nxt      = rd_any ? ST_RD : ST_DONE;
            end
            ST_RD: begin
                lane_vld = 1'b1;
                SIMD_SEL = lane_sel;
                if (out_rdy && lane_last)
                    nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                nxt  = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_simd_issue_seq.sv
// Directed bench for simd_issue_seq: hand-computed per-cycle expectations.
module tb_simd_issue_seq;
    import simd_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [FSW-1:0]   op = '0;
    logic [4:0]       s_addr = '0;
    logic [4:0]       t_addr = '0;
    logic [4:0]       d_addr = '0;
    logic             wb_en = 1'b0;
    logic             hi_en = 1'b0;
    logic [1:0]       rd_mode = 2'b00;
    logic             out_rdy = 1'b1;
    logic [31:0]      ADDRS;
    logic [FSW-1:0]   FS;
    logic             s_ld, t_ld, d_ld, lo_ld, hi_ld, DSIMD_EN;
    logic [SEL_W-1:0] SIMD_SEL;
    logic             lane_vld, busy, done;

    logic [49:0] all_out;
    assign all_out = {ADDRS, FS, s_ld, t_ld, d_ld, lo_ld, hi_ld, DSIMD_EN,
                      SIMD_SEL, lane_vld, busy, done};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers = 0;

    simd_issue_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .s_addr   (s_addr),
        .t_addr   (t_addr),
        .d_addr   (d_addr),
        .wb_en    (wb_en),
        .hi_en    (hi_en),
        .rd_mode  (rd_mode),
        .out_rdy  (out_rdy),
        .ADDRS    (ADDRS),
        .FS       (FS),
        .s_ld     (s_ld),
        .t_ld     (t_ld),
        .d_ld     (d_ld),
        .lo_ld    (lo_ld),
        .hi_ld    (hi_ld),
        .DSIMD_EN (DSIMD_EN),
        .SIMD_SEL (SIMD_SEL),
        .lane_vld (lane_vld),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive a request so it is sampled at edge 0; returns inside cycle 1.
    task automatic issue(input logic [FSW-1:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic wb, input logic hi, input logic [1:0] rd);
        op = o; s_addr = s; t_addr = t; d_addr = d;
        wb_en = wb; hi_en = hi; rd_mode = rd;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    // wb=1, hi=1, rd=11 with out_rdy high: WB in 5, lanes 0..15 in 6..21, done in 22.
    task automatic run_full(input string p);
        out_rdy = 1'b1;
        issue(5'h07, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 2'b11);
        chk({p, "_c1_addr"}, ADDRS, 32'd1);
        step(); step(); step();
        chk({p, "_c4_lo"}, lo_ld, 1'b1);
        chk({p, "_c4_hi"}, hi_ld, 1'b1);
        step();
        chk({p, "_c5_wb"}, DSIMD_EN, 1'b1);
        chk({p, "_c5_vld"}, lane_vld, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk({p, "_rd_vld"}, lane_vld, 1'b1);
            chk({p, "_rd_sel"}, SIMD_SEL, 64'(k));
            chk({p, "_rd_wb"}, DSIMD_EN, 1'b0);
            chk({p, "_rd_done"}, done, 1'b0);
        end
        step();
        chk({p, "_c22_done"}, done, 1'b1);
        chk({p, "_c22_vld"}, lane_vld, 1'b0);
        chk({p, "_c22_fs"}, FS, 5'h07);
        step();
        chk({p, "_c23_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_sel [14] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, 7, 7, 7};

        // Reset state
        #1;
        chk("rst_outs", all_out, '0);
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_idle_outs", all_out, '0);

        // Basic: no WB, no readout; changed inputs after accept must not matter
        issue(5'h02, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 2'b00);
        op = 5'h1f; s_addr = 5'd9; t_addr = 5'd9; d_addr = 5'd9; hi_en = 1'b1;
        chk("b_c1_sld", s_ld, 1'b1);
        chk("b_c1_addr", ADDRS, 32'd3);
        chk("b_c1_fs", FS, 5'h02);
        chk("b_c1_busy", busy, 1'b1);
        step();
        chk("b_c2_tld", t_ld, 1'b1);
        chk("b_c2_sld", s_ld, 1'b0);
        chk("b_c2_addr", ADDRS, 32'd4);
        chk("b_c2_fs", FS, 5'h02);
        step();
        chk("b_c3_dld", d_ld, 1'b1);
        chk("b_c3_addr", ADDRS, 32'd5);
        chk("b_c3_fs", FS, 5'h02);
        step();
        chk("b_c4_lo", lo_ld, 1'b1);
        chk("b_c4_hi", hi_ld, 1'b0);
        chk("b_c4_addr", ADDRS, 32'd0);
        chk("b_c4_wb", DSIMD_EN, 1'b0);
        chk("b_c4_fs", FS, 5'h02);
        step();
        chk("b_c5_done", done, 1'b1);
        chk("b_c5_busy", busy, 1'b1);
        chk("b_c5_wb", DSIMD_EN, 1'b0);
        chk("b_c5_fs", FS, 5'h02);
        step();
        chk("b_c6_done", done, 1'b0);
        chk("b_c6_outs", all_out, '0);

        // Full sequence
        run_full("full");

        // Backpressure: stalls at SIMD_SEL=2 (cycles 7-9) and SIMD_SEL=7 (cycles 15-17)
        issue(5'h04, 5'd11, 5'd12, 5'd13, 1'b0, 1'b0, 2'b01);
        step(); step(); step(); step();
        xfers = 0;
        for (int i = 0; i < 14; i++) begin
            out_rdy = (cyc inside {7, 8, 9, 15, 16, 17}) ? 1'b0 : 1'b1;
            chk("bp_sel", SIMD_SEL, 64'(bp_sel[i]));
            chk("bp_vld", lane_vld, 1'b1);
            if (lane_vld && out_rdy)
                xfers++;
            step();
        end
        out_rdy = 1'b1;
        chk("bp_c19_done", done, 1'b1);
        chk("bp_xfers", 64'(xfers), 64'd8);
        step();
        chk("bp_idle", busy, 1'b0);

        // HI-only readout
        issue(5'h05, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1, 2'b10);
        step(); step(); step();
        chk("hi_c4_hild", hi_ld, 1'b1);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("hi_sel", SIMD_SEL, 64'(8 + k));
            chk("hi_vld", lane_vld, 1'b1);
            step();
        end
        chk("hi_c13_done", done, 1'b1);
        step();

        // Start during EXEC is ignored and not queued
        issue(5'h03, 5'd6, 5'd7, 5'd8, 1'b0, 1'b0, 2'b00);
        step(); step(); step();
        start = 1'b1; op = 5'h09; s_addr = 5'd10; t_addr = 5'd11; d_addr = 5'd12;
        wb_en = 1'b1; rd_mode = 2'b11;
        chk("ign_c4_addr", ADDRS, 32'd0);
        chk("ign_c4_fs", FS, 5'h03);
        step();
        start = 1'b0;
        chk("ign_c5_done", done, 1'b1);
        chk("ign_c5_fs", FS, 5'h03);
        chk("ign_c5_wb", DSIMD_EN, 1'b0);
        step();
        chk("ign_c6_busy", busy, 1'b0);
        step();
        chk("ign_c7_busy", busy, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_new_sld", s_ld, 1'b1);
        chk("ign_new_addr", ADDRS, 32'd10);
        chk("ign_new_fs", FS, 5'h09);
        wait_idle("ign_new_tmo", 40);

        // Reset mid-readout at SIMD_SEL=4
        issue(5'h06, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 2'b01);
        step(); step(); step(); step();
        step(); step(); step(); step();
        chk("rmid_pre_sel", SIMD_SEL, 64'd4);
        reset = 1'b1;
        #1;
        chk("rmid_outs", all_out, '0);
        step();
        chk("rmid_hold_outs", all_out, '0);
        reset = 1'b0;
        step();
        chk("rmid_no_done", done, 1'b0);
        chk("rmid_idle", busy, 1'b0);
        run_full("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
